// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
// One request at a time: req/gnt for the address phase, rvalid/rdata for the data phase.
interface instr_fetch_unit_if #(
    parameter int Width = 32
);
    logic             imem_req;
    logic [Width-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [Width-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one request per PC to instruction memory, holds the returned word for
// decode, pulses pc_advance on accept, and handles redirect flushes and misaligned PCs.
module instr_fetch_unit #(
    parameter int               Width    = 32,
    parameter logic [Width-1:0] NopInstr = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [Width-1:0]          pc_in,
    output logic                      pc_advance,
    input  logic                      flush,
    instr_fetch_unit_if.master        imem,
    output logic                      instr_valid,
    output logic [Width-1:0]          instr,
    output logic [Width-1:0]          instr_pc,
    input  logic                      instr_ready,
    output logic                      fetch_misaligned
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } state_e;

    state_e           state_q;
    logic             valid_q;
    logic [Width-1:0] instr_q;
    logic [Width-1:0] instr_pc_q;
    logic             misaligned_q;
    logic [Width-1:0] addr_q;

    logic pc_misaligned;
    logic req_issued;

    assign pc_misaligned = |pc_in[1:0];

    // A misaligned PC never reaches memory; it is answered locally with a NOP.
    assign imem.imem_req  = (state_q == REQ) && !pc_misaligned;
    assign imem.imem_addr = {pc_in[Width-1:2], 2'b00};
    assign req_issued     = imem.imem_req && imem.imem_gnt;

    assign pc_advance       = (state_q == HOLD) && instr_ready && !flush;
    assign instr_valid      = valid_q;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;
    assign fetch_misaligned = misaligned_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            instr_q      <= NopInstr;
            instr_pc_q   <= '0;
            misaligned_q <= 1'b0;
            addr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;

                REQ: begin
                    if (flush) begin
                        // A request granted alongside the flush still owes a response.
                        state_q <= req_issued ? DROP : REQ;
                    end else if (pc_misaligned) begin
                        instr_q      <= NopInstr;
                        instr_pc_q   <= pc_in;
                        misaligned_q <= 1'b1;
                        valid_q      <= 1'b1;
                        state_q      <= HOLD;
                    end else if (imem.imem_gnt) begin
                        addr_q  <= pc_in;
                        state_q <= WAIT;
                    end
                end

                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (flush) begin
                            state_q <= REQ;
                        end else begin
                            instr_q      <= imem.imem_rdata;
                            instr_pc_q   <= addr_q;
                            misaligned_q <= 1'b0;
                            valid_q      <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end else if (flush) begin
                        state_q <= DROP;
                    end
                end

                HOLD: begin
                    if (flush) begin
                        valid_q <= 1'b0;
                        instr_q <= NopInstr;
                        state_q <= REQ;
                    end else if (instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= REQ;
                    end
                end

                // A flush here changes nothing: the stale response is still owed and discarded.
                DROP: begin
                    if (imem.imem_rvalid) begin
                        state_q <= REQ;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC register and variable-latency memory models,
// hand-computed expectations for reset, streaming, backpressure, flushes and misaligned PCs.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        instr_ready;
    logic        pc_advance;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misaligned;
    logic [31:0] pc_in;
    logic [31:0] pc_q;
    logic        pc_force;
    logic [31:0] pc_force_val;

    int n_checks = 0;
    int n_fail   = 0;

    int          gnt_dly;
    int          rv_dly;
    int          req_wait;
    logic        pend;
    int          rv_cnt;
    logic [31:0] pend_addr;

    int cyc      = 0;
    int adv_cnt  = 0;
    int adv_last = 0;
    int adv_prev = 0;
    int req_cnt  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.Width(32)) bus ();

    instr_fetch_unit #(.Width(32), .NopInstr(32'h0000_0013)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_in            (pc_in),
        .pc_advance       (pc_advance),
        .flush            (flush),
        .imem             (bus),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_ready      (instr_ready),
        .fetch_misaligned (fetch_misaligned)
    );

    // PC register: a redirect is visible immediately and loaded at the edge.
    assign pc_in = pc_force ? pc_force_val : pc_q;
    always @(posedge clk or posedge reset) begin
        if (reset)            pc_q <= 32'h0;
        else if (pc_force)    pc_q <= pc_force_val;
        else if (pc_advance)  pc_q <= pc_q + 32'd4;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_8113;
            default: return a ^ 32'hCAFE_0000;
        endcase
    endfunction

    // Memory: gnt after gnt_dly waiting cycles, rvalid rv_dly cycles after the grant.
    assign bus.imem_gnt    = bus.imem_req && (req_wait >= gnt_dly);
    assign bus.imem_rvalid = pend && (rv_cnt >= rv_dly);
    assign bus.imem_rdata  = bus.imem_rvalid ? mem_word(pend_addr) : 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            req_wait  <= 0;
            pend      <= 1'b0;
            rv_cnt    <= 0;
            pend_addr <= 32'h0;
        end else begin
            req_wait <= (bus.imem_req && !bus.imem_gnt) ? req_wait + 1 : 0;
            if (bus.imem_req && bus.imem_gnt) begin
                pend      <= 1'b1;
                pend_addr <= bus.imem_addr;
                rv_cnt    <= 1;
            end else if (bus.imem_rvalid) begin
                pend <= 1'b0;
            end else if (pend) begin
                rv_cnt <= rv_cnt + 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (pc_advance) begin
                adv_cnt  <= adv_cnt + 1;
                adv_prev <= adv_last;
                adv_last <= cyc;
            end
            if (bus.imem_req && bus.imem_gnt) req_cnt <= req_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!instr_valid && n < max_cycles) begin
            step();
            n++;
        end
        check(tag, {31'd0, instr_valid}, 32'd1);
    endtask

    int  adv_base;
    int  req_base;
    logic saw_valid;

    initial begin
        reset = 1'b1; flush = 1'b0; instr_ready = 1'b0;
        pc_force = 1'b0; pc_force_val = 32'h0;
        gnt_dly = 0; rv_dly = 1;

        // Reset release
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_adv", {31'd0, pc_advance}, 32'd0);
        check("rst_misal", {31'd0, fetch_misaligned}, 32'd0);
        reset = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("idle_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, 32'h0);

        // Best-case stream
        wait_valid("bc0_valid", 10);
        check("bc0_instr", instr, 32'h0050_0093);
        check("bc0_pc", instr_pc, 32'h0);
        step();
        wait_valid("bc1_valid", 10);
        check("bc1_instr", instr, 32'h0010_8113);
        check("bc1_pc", instr_pc, 32'h4);
        gnt_dly = 2; rv_dly = 3;
        step();
        check("bc_adv_spacing", adv_last - adv_prev, 32'd3);

        // Variable latency and backpressure at 0x8
        instr_ready = 1'b0;
        adv_base = adv_cnt;
        req_base = req_cnt;
        wait_valid("bp_valid", 20);
        check("bp_instr", instr, 32'hCAFE_0008);
        check("bp_pc", instr_pc, 32'h8);
        check("bp_misal", {31'd0, fetch_misaligned}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_instr", instr, 32'hCAFE_0008);
            check("bp_hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        instr_ready = 1'b1;
        #1;
        check("bp_adv_pulse", {31'd0, pc_advance}, 32'd1);
        step();
        check("bp_adv_count", adv_cnt - adv_base, 32'd1);
        check("bp_req_count", req_cnt - req_base, 32'd1);

        // Flush in WAIT: fetch 0x8 again, redirect to 0x40 the cycle after grant
        instr_ready = 1'b0;
        gnt_dly = 0; rv_dly = 3;
        pc_force = 1'b1; pc_force_val = 32'h8;
        adv_base = adv_cnt;
        step();
        flush = 1'b1; pc_force = 1'b1; pc_force_val = 32'h40;
        #1;
        check("fw_adv", {31'd0, pc_advance}, 32'd0);
        step();
        flush = 1'b0; pc_force = 1'b0;
        saw_valid = 1'b0;
        for (int n = 0; n < 10 && !bus.imem_req; n++) begin
            step();
            if (instr_valid) saw_valid = 1'b1;
        end
        check("fw_no_valid", {31'd0, saw_valid}, 32'd0);
        check("fw_req", {31'd0, bus.imem_req}, 32'd1);
        check("fw_addr", bus.imem_addr, 32'h40);
        check("fw_adv_count", adv_cnt - adv_base, 32'd0);

        // Flush coincident with accept in HOLD
        rv_dly = 1;
        wait_valid("fh_valid", 10);
        check("fh_instr", instr, 32'hCAFE_0040);
        check("fh_pc", instr_pc, 32'h40);
        adv_base = adv_cnt;
        flush = 1'b1; instr_ready = 1'b1; pc_force = 1'b1; pc_force_val = 32'h80;
        #1;
        check("fh_adv", {31'd0, pc_advance}, 32'd0);
        step();
        flush = 1'b0; instr_ready = 1'b0; pc_force = 1'b0;
        check("fh_valid_fall", {31'd0, instr_valid}, 32'd0);
        check("fh_instr_nop", instr, 32'h0000_0013);
        check("fh_req", {31'd0, bus.imem_req}, 32'd1);
        check("fh_addr", bus.imem_addr, 32'h80);
        check("fh_adv_count", adv_cnt - adv_base, 32'd0);

        // Misaligned PC
        req_base = req_cnt;
        pc_force = 1'b1; pc_force_val = 32'h102;
        #1;
        check("ma_no_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        pc_force = 1'b0;
        check("ma_valid", {31'd0, instr_valid}, 32'd1);
        check("ma_flag", {31'd0, fetch_misaligned}, 32'd1);
        check("ma_pc", instr_pc, 32'h102);
        check("ma_instr", instr, 32'h0000_0013);
        instr_ready = 1'b1;
        #1;
        check("ma_adv", {31'd0, pc_advance}, 32'd1);
        step();
        instr_ready = 1'b0;
        check("ma_valid_fall", {31'd0, instr_valid}, 32'd0);
        check("ma_req_count", req_cnt - req_base, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetch stage between the program counter register and decode.
- Takes the current PC and issues one request at a time to a variable-latency instruction memory using a req/gnt/rvalid handshake.
- Holds the returned word in an output register with a valid/ready handshake to decode.
- Pulses `pc_advance` to let the PC register load its next value; handles redirect flushes and misaligned PCs.

## Interface

Parameters:
- `Width`, default 32: address and instruction width.
- `NopInstr`, default 32'h0000_0013: value of `instr` at reset and after a flush (addi x0,x0,0).

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `pc_in`, in, Width: current PC from the PC register.
- `pc_advance`, out, 1: one-cycle pulse; the PC register loads the next PC on this cycle's edge.
- `flush`, in, 1: redirect (branch/jump taken); discard held and in-flight instructions.
- `imem_req`, out, 1: request valid.
- `imem_addr`, out, Width: word-aligned request address.
- `imem_gnt`, in, 1: memory accepts the request this cycle.
- `imem_rvalid`, in, 1: read data valid.
- `imem_rdata`, in, Width: read data.
- `instr_valid`, out, 1: `instr` / `instr_pc` valid for decode.
- `instr`, out, Width: fetched instruction.
- `instr_pc`, out, Width: address of `instr`.
- `instr_ready`, in, 1: decode accepts this cycle.
- `fetch_misaligned`, out, 1: qualifies `instr_valid`; `instr_pc[1:0]` != 0, so `instr` is `NopInstr`.

## Operation

States: IDLE, REQ, WAIT, DROP, HOLD.

Transitions:
- **IDLE**: leave after one cycle out of reset, to REQ.
- **REQ**: `imem_req`=1 and `imem_addr`={`pc_in`[Width-1:2],2'b00}, driven combinationally.
  - If `pc_in[1:0]` != 0: no request is issued (`imem_req`=0). Load `instr_pc`=`pc_in`, `instr`=`NopInstr`, `fetch_misaligned`=1, go to HOLD.
  - On `imem_gnt`: latch `pc_in` into an internal address register, go to WAIT.
- **WAIT**: on `imem_rvalid`, register `instr`=`imem_rdata`, `instr_pc`=latched address, `fetch_misaligned`=0, go to HOLD.
- **HOLD**: `instr_valid`=1. On `instr_ready`, pulse `pc_advance`=1 and go to REQ.
- **DROP**: wait for `imem_rvalid`, discard the data, go to REQ. `instr_valid`=0 throughout.

Flush (evaluated before all other transitions):
- REQ, or HOLD with `instr_ready`: no `pc_advance`, `instr_valid` cleared.
  - REQ with `imem_gnt` in the same cycle: go to DROP.
  - Otherwise: stay in or go to REQ.
- WAIT without `imem_rvalid`: go to DROP.
- WAIT with `imem_rvalid`: discard the data, go to REQ.
- HOLD: clear `instr_valid`, set `instr`=`NopInstr`, go to REQ.
- DROP: stay in DROP.

Rules:
- Exactly one request outstanding at a time.
- `imem_req` only in REQ.
- `imem_rvalid` outside WAIT/DROP is ignored.
- `imem_addr` and `instr_pc` are passed through with no arithmetic. PC wrap-around (0xFFFF_FFFC then 0x0) is the PC register's concern; this block passes it through unmodified.
- `instr`, `instr_pc` and `fetch_misaligned` are stable while `instr_valid`=1 and `instr_ready`=0.

## Timing

Reset values, held while `reset`=1:
- state = IDLE
- `imem_req`=0, `pc_advance`=0, `instr_valid`=0, `fetch_misaligned`=0
- `instr`=`NopInstr`, `instr_pc`=0

Latency and throughput:
- `imem_rvalid` is legal no earlier than the cycle after `imem_gnt`.
- `instr_valid` rises on the edge after `imem_rvalid`.
- Best case, with `gnt` in the request cycle, `rvalid` one cycle later and `instr_ready` held high: one instruction per 3 cycles (REQ, WAIT, HOLD).

`pc_advance` handshake:
- Combinational, equal to (HOLD & `instr_ready` & !`flush`).
- `pc_in` must show the new PC by the next REQ cycle.

Reset mid-operation:
- Returns to IDLE immediately and drops any in-flight response.
- The memory must also be reset.

## Test plan

- **Reset release**: hold `reset` 3 cycles with `pc_in`=0x0, then release. `imem_req`=0 for one cycle (IDLE), then `imem_req`=1 with `imem_addr`=0x0. All outputs are at reset values during reset.
- **Best-case stream**: memory with `gnt`=1 and 1-cycle `rvalid` returning mem[0x0]=0x00500093 and mem[0x4]=0x00108113; `instr_ready`=1; the PC increments by 4 on `pc_advance`. `instr`/`instr_pc` = 0x00500093/0x0 then 0x00108113/0x4, with `pc_advance` once every 3 cycles.
- **Variable latency and backpressure**: `gnt` delayed 2 cycles, `rvalid` delayed 3 cycles, `instr_ready`=0 for 4 cycles. A single request is issued; `instr` is held stable; exactly one `pc_advance`, on the cycle `instr_ready` rises.
- **Flush in WAIT**: raise `flush` one cycle after `gnt` at 0x8 and change `pc_in` to 0x40. The 0x8 data is discarded (`instr_valid` stays 0), the next request has `imem_addr`=0x40, and there is no `pc_advance`.
- **Flush coincident with accept in HOLD**: `flush`=1 and `instr_ready`=1 together. `pc_advance`=0, `instr_valid` falls, `instr`=0x00000013, and the next request uses the new `pc_in`.
- **Misaligned PC**: `pc_in`=0x102. No `imem_req`; `instr_valid`=1 with `fetch_misaligned`=1, `instr_pc`=0x102 and `instr`=0x00000013. `pc_advance` pulses when `instr_ready`=1.
